// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the sequencer state type.
// Used by the ALU, the sequencer and their benches.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_ADD = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_MOD = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      MOD_CMP,
      MOD_SUB,
      RESP
   } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences valid/ready requests onto a combinational 32-bit ALU; MOD is
// run as a compare/subtract loop on the same ALU with error detection.
//
// state   | meaning
// IDLE    | ready for a request, ALU inputs parked at zero
// EXEC    | latched request on the ALU; single-cycle ops finish here
// MOD_CMP | SLT rem,b: rem < b means rem is the remainder
// MOD_SUB | SUB rem,b: rem shrinks by b, iteration count bumps
// RESP    | response held until rsp_ready
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_ITER = 1024
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_cout,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_ain,
   output logic [WIDTH-1:0] alu_bin,
   output logic [2:0]       alu_op,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);

   localparam int IW = $clog2(MAX_ITER + 1);
   localparam logic [IW-1:0] ITER_LIM = IW'(MAX_ITER);

   state_t           state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic [WIDTH-1:0] rem;
   logic [IW-1:0]    iter;
   logic [IW-1:0]    iter_nxt;
   logic             mod_bad;

   assign req_ready = (state == IDLE);
   assign iter_nxt  = iter + IW'(1);
   // remainder loop only handles non-negative signed operands and a nonzero divisor
   assign mod_bad   = (b_q == '0) || a_q[WIDTH-1] || b_q[WIDTH-1];

   always_comb begin
      alu_ain = '0;
      alu_bin = '0;
      alu_op  = ALU_AND;
      alu_cin = 1'b0;
      case (state)
         EXEC: begin
            alu_ain = a_q;
            alu_bin = b_q;
            alu_op  = op_q;
            alu_cin = cin_q;
         end
         MOD_CMP: begin
            alu_ain = rem;
            alu_bin = b_q;
            alu_op  = ALU_SLT;
         end
         MOD_SUB: begin
            alu_ain = rem;
            alu_bin = b_q;
            alu_op  = ALU_SUB;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         rem        <= '0;
         iter       <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_cout   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  a_q   <= req_a;
                  b_q   <= req_b;
                  cin_q <= req_cin;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (op_q != ALU_MOD) begin
                  rsp_result <= alu_result;
                  rsp_cout   <= alu_cout;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (mod_bad) begin
                  rsp_result <= a_q;
                  rsp_cout   <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  rem   <= a_q;
                  iter  <= '0;
                  state <= MOD_CMP;
               end
            end
            MOD_CMP: begin
               if (alu_result[0]) begin
                  rsp_result <= rem;
                  rsp_cout   <= 1'b0;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  state <= MOD_SUB;
               end
            end
            MOD_SUB: begin
               rem  <= alu_result;
               iter <= iter_nxt;
               if (iter_nxt == ITER_LIM) begin
                  rsp_result <= alu_result;
                  rsp_cout   <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  state <= MOD_CMP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer paired with a behavioural ALU; a second instance
// with MAX_ITER=4 exercises the iteration-limit abort.
module tb_alu_sequencer;
   import alu_pkg::*;

   typedef struct {
      bit          sel;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] res;
      logic        cout;
      logic        err;
      int          lat;
   } vec_t;

   logic        CLK = 1'b0;
   logic        reset;
   logic        req_valid0, req_valid1;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        req_cin;
   logic        rsp_ready;

   logic        req_ready0, rsp_valid0, rsp_cout0, rsp_err0, alu_cin0, alu_cout0;
   logic [31:0] rsp_result0, alu_ain0, alu_bin0, alu_result0;
   logic [2:0]  alu_op0;
   logic        req_ready1, rsp_valid1, rsp_cout1, rsp_err1, alu_cin1, alu_cout1;
   logic [31:0] rsp_result1, alu_ain1, alu_bin1, alu_result1;
   logic [2:0]  alu_op1;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];
   vec_t sb[$];
   int slt_n, sub_n;
   bit mon_en = 1'b0;

   always #5 CLK = ~CLK;

   function automatic logic [32:0] alu_f(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic cin);
      case (op)
         ALU_AND: return {1'b0, a & b};
         ALU_OR:  return {1'b0, a | b};
         ALU_XOR: return {1'b0, a ^ b};
         ALU_NOR: return {1'b0, ~(a | b)};
         ALU_SLT: return {32'd0, ($signed(a) < $signed(b))};
         ALU_ADD: return {1'b0, a} + {1'b0, b} + {32'd0, cin};
         ALU_SUB: return {1'b0, a} + {1'b0, ~b} + 33'd1;
         default: return 33'd0;
      endcase
   endfunction

   assign {alu_cout0, alu_result0} = alu_f(alu_op0, alu_ain0, alu_bin0, alu_cin0);
   assign {alu_cout1, alu_result1} = alu_f(alu_op1, alu_ain1, alu_bin1, alu_cin1);

   alu_sequencer #(.WIDTH(32), .MAX_ITER(1024)) dut (
      .CLK(CLK), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_result(rsp_result0),
      .rsp_cout(rsp_cout0), .rsp_err(rsp_err0),
      .alu_ain(alu_ain0), .alu_bin(alu_bin0), .alu_op(alu_op0), .alu_cin(alu_cin0),
      .alu_result(alu_result0), .alu_cout(alu_cout0)
   );

   alu_sequencer #(.WIDTH(32), .MAX_ITER(4)) dut4 (
      .CLK(CLK), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_result1),
      .rsp_cout(rsp_cout1), .rsp_err(rsp_err1),
      .alu_ain(alu_ain1), .alu_bin(alu_bin1), .alu_op(alu_op1), .alu_cin(alu_cin1),
      .alu_result(alu_result1), .alu_cout(alu_cout1)
   );

   always @(posedge CLK) begin
      if (mon_en) begin
         if (alu_op0 == ALU_SLT) slt_n++;
         if (alu_op0 == ALU_SUB) sub_n++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin);
      int n;
      n = 0;
      while ((sel ? req_ready1 : req_ready0) !== 1'b1 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      check("req_ready before issue", {63'd0, (sel ? req_ready1 : req_ready0)}, 64'd1);
      req_op = op; req_a = a; req_b = b; req_cin = cin;
      if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
      @(posedge CLK); #1;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
   endtask

   task automatic wait_rsp(input bit sel, output int lat);
      lat = 0;
      do begin
         @(posedge CLK); #1;
         lat++;
      end while ((sel ? rsp_valid1 : rsp_valid0) !== 1'b1 && lat < 4000);
      if (lat >= 4000) check("response timeout", 64'd1, 64'd0);
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic compare_rsp(input bit sel, input int lat);
      vec_t e;
      if (sb.size() == 0) begin
         check("scoreboard empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      check("rsp_result", {32'd0, (sel ? rsp_result1 : rsp_result0)}, {32'd0, e.res});
      check("rsp_cout", {63'd0, (sel ? rsp_cout1 : rsp_cout0)}, {63'd0, e.cout});
      check("rsp_err", {63'd0, (sel ? rsp_err1 : rsp_err0)}, {63'd0, e.err});
      check("latency", 64'(lat), 64'(e.lat));
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      sb.push_back(v);
      issue(v.sel, v.op, v.a, v.b, v.cin);
      wait_rsp(v.sel, lat);
      compare_rsp(v.sel, lat);
      handshake();
   endtask

   initial begin
      int lat;
      vec_t v;
      logic [32:0] r;
      reset = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0;
      req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0; rsp_ready = 1'b0;

      tbl.push_back('{0, ALU_AND, 32'd5, 32'd7, 1'b0, 32'd5, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_NOR, 32'd5, 32'd7, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_ADD, 32'd10, 32'd6, 1'b0, 32'd16, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_ADD, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1});
      tbl.push_back('{0, ALU_ADD, 32'd10, 32'd6, 1'b1, 32'd17, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_OR, 32'hF0, 32'h0F, 1'b0, 32'hFF, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_XOR, 32'hFF, 32'h0F, 1'b0, 32'hF0, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_SLT, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, 1});
      tbl.push_back('{0, ALU_MOD, 32'd2, 32'd5, 1'b0, 32'd2, 1'b0, 1'b0, 2});
      tbl.push_back('{0, ALU_MOD, 32'd5, 32'd0, 1'b0, 32'd5, 1'b0, 1'b1, 1});
      tbl.push_back('{0, ALU_MOD, 32'h80000000, 32'd3, 1'b0, 32'h80000000, 1'b0, 1'b1, 1});
      tbl.push_back('{0, ALU_MOD, 32'd12, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0, 8});
      tbl.push_back('{1, ALU_MOD, 32'd100, 32'd3, 1'b0, 32'd88, 1'b0, 1'b1, 9});
      tbl.push_back('{1, ALU_MOD, 32'd10, 32'd3, 1'b0, 32'd1, 1'b0, 1'b0, 8});

      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      check("reset req_ready", {63'd0, req_ready0}, 64'd1);
      check("reset rsp_valid", {63'd0, rsp_valid0}, 64'd0);
      check("reset rsp_result", {32'd0, rsp_result0}, 64'd0);
      check("reset alu_op", {61'd0, alu_op0}, 64'd0);

      foreach (tbl[i]) run_vec(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         v.sel = 0;
         v.op  = 3'($urandom_range(0, 6));
         v.a   = $urandom;
         v.b   = $urandom;
         v.cin = 1'($urandom_range(0, 1));
         r     = alu_f(v.op, v.a, v.b, v.cin);
         v.res = r[31:0]; v.cout = r[32]; v.err = 1'b0; v.lat = 1;
         run_vec(v);
      end

      // remainder of 47 by 3: 15 subtractions, 16 compares
      slt_n = 0; sub_n = 0; mon_en = 1'b1;
      run_vec('{0, ALU_MOD, 32'd47, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 32});
      mon_en = 1'b0;
      check("slt cycles", 64'(slt_n), 64'd16);
      check("sub cycles", 64'(sub_n), 64'd15);

      // back-pressure with a competing request held by the requester
      issue(0, ALU_AND, 32'hF0, 32'h3C, 1'b0);
      wait_rsp(0, lat);
      check("bp latency", 64'(lat), 64'd1);
      req_op = ALU_ADD; req_a = 32'd1; req_b = 32'd1; req_cin = 1'b0;
      req_valid0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         check("bp rsp_valid", {63'd0, rsp_valid0}, 64'd1);
         check("bp rsp_result", {32'd0, rsp_result0}, 64'h30);
         check("bp req_ready", {63'd0, req_ready0}, 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      check("bp idle after handshake", {63'd0, rsp_valid0}, 64'd0);
      @(posedge CLK); #1;
      req_valid0 = 1'b0;
      wait_rsp(0, lat);
      check("held req result", {32'd0, rsp_result0}, 64'd2);
      check("held req latency", 64'(lat), 64'd1);
      handshake();

      // reset in the middle of a MOD, after the third subtraction
      issue(0, ALU_MOD, 32'd47, 32'd3, 1'b0);
      sub_n = 0;
      for (int i = 0; i < 50 && sub_n < 3; i++) begin
         @(posedge CLK); #1;
         if (alu_op0 == ALU_SUB) sub_n++;
      end
      check("reached third sub", 64'(sub_n), 64'd3);
      reset = 1'b1;
      @(posedge CLK); #1;
      check("mid-mod reset rsp_valid", {63'd0, rsp_valid0}, 64'd0);
      check("mid-mod reset rsp_result", {32'd0, rsp_result0}, 64'd0);
      check("mid-mod reset alu_op", {61'd0, alu_op0}, 64'd0);
      check("mid-mod reset alu_ain", {32'd0, alu_ain0}, 64'd0);
      check("mid-mod reset alu_bin", {32'd0, alu_bin0}, 64'd0);
      check("mid-mod reset req_ready", {63'd0, req_ready0}, 64'd1);
      reset = 1'b0;
      @(posedge CLK); #1;
      check("post reset rsp_valid", {63'd0, rsp_valid0}, 64'd0);
      run_vec('{0, ALU_SUB, 32'd9, 32'd4, 1'b0, 32'd5, 1'b1, 1'b0, 1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
